// File: rtl/uvect_pkg.sv
// -----------------------------------------------------------------------------
// uvect_pkg -- shared types and constants for the micro-vector interrupt
// controller that sits beside an Am2910 sequencer.
//
// Contents:
//   prio_idx_t    : 3-bit interrupt priority index (7 = highest priority)
//   *_DEF         : default map page, vector page and spurious vector
//   make_vector() : {page, idx, 3'b000} interrupt vector layout
//   make_map()    : {page, opcode, 2'b00} mapping address layout
//   onehot()      : index -> one-hot bit mask
// -----------------------------------------------------------------------------
package uvect_pkg;

    localparam int NUM_IRQ = 8;

    typedef logic [2:0] prio_idx_t;

    localparam logic [1:0]  MAP_PAGE_DEF = 2'b01;
    localparam logic [5:0]  VEC_PAGE_DEF = 6'b111111;
    localparam logic [11:0] SPUR_VEC_DEF = 12'hFB8;

    // Each vector entry is eight microwords long, so the index lands at [5:3].
    function automatic logic [11:0] make_vector(input logic [5:0] page,
                                                input prio_idx_t  idx);
        return {page, idx, 3'b000};
    endfunction

    // Each opcode owns four microwords of the mapping page.
    function automatic logic [11:0] make_map(input logic [1:0] page,
                                             input logic [7:0] op);
        return {page, op, 2'b00};
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input prio_idx_t idx);
        return NUM_IRQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uvect_prio.sv
// -----------------------------------------------------------------------------
// uvect_prio -- 8-bit priority encoder, bit 7 highest priority.
//
// Ports:
//   req   in  8  request vector
//   valid out 1  at least one request bit is set
//   idx   out 3  index of the highest set request bit (0 when none)
// -----------------------------------------------------------------------------
module uvect_prio
    import uvect_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output prio_idx_t          idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        valid = |req;
        idx   = '0;
        // Ascending scan: the last (highest) set bit overwrites lower ones.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) idx = prio_idx_t'(i);
        end
    end

endmodule

// File: rtl/uvect_ctrl.sv
// -----------------------------------------------------------------------------
// uvect_ctrl -- opcode map / interrupt vector source for an Am2910 sequencer.
//
// Drives the sequencer D input from the pipeline branch field, the opcode
// mapping address or a registered interrupt vector, and runs an 8-level
// edge-triggered interrupt controller (pending / mask / in-service).
//
// Build option: define UVECT_NEST_EN for nested priority (a higher-priority
// request may preempt one in service). Without it, a single level is served
// and eoi clears the whole in-service register.
//
// Ports:
//   clk              in   1  clock, all state on the rising edge
//   nRESET           in   1  asynchronous active-low reset
//   nPL/nMAP/nVECT   in   1  Am2910 source enables, active-low, one-hot-low
//   nCCEN, nCC       in   1  sequencer condition enable / condition
//   pl_d             in  12  pipeline-register branch field
//   op_load, opcode  in 1,8  opcode register load strobe / data
//   irq              in   8  synchronous request lines, bit 7 highest
//   mask_we, mask_wd in 1,8  mask write strobe / data (1 = enabled)
//   eoi              in   1  end-of-interrupt pulse
//   D                out 12  sequencer D input
//   int_req          out  1  registered: an eligible interrupt exists
//   pending, isr     out  8  pending and in-service registers
// -----------------------------------------------------------------------------
module uvect_ctrl
    import uvect_pkg::*;
#(
    parameter logic [1:0]  MAP_PAGE = MAP_PAGE_DEF,
    parameter logic [5:0]  VEC_PAGE = VEC_PAGE_DEF,
    parameter logic [11:0] SPUR_VEC = SPUR_VEC_DEF
) (
    input  logic               clk,
    input  logic               nRESET,
    input  logic               nPL,
    input  logic               nMAP,
    input  logic               nVECT,
    input  logic               nCCEN,
    input  logic               nCC,
    input  logic [11:0]        pl_d,
    input  logic               op_load,
    input  logic [7:0]         opcode,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wd,
    input  logic               eoi,
    output logic [11:0]        D,
    output logic               int_req,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] isr
);

    logic [7:0]         opcode_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [11:0]        vec_q;
    logic               int_req_q;
    prio_idx_t          ack_idx_q;   // index behind the vector currently held

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] above;       // priorities allowed to be taken now
    logic [NUM_IRQ-1:0] isr_after_eoi;
    logic [NUM_IRQ-1:0] eligible;
    logic               elig_valid;
    prio_idx_t          elig_idx;
    logic               ack;
    logic [NUM_IRQ-1:0] ack_bit;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] isr_next;

    assign rise = irq & ~irq_q;

`ifdef UVECT_NEST_EN
    logic      isr_valid;
    prio_idx_t isr_top;

    uvect_prio u_isr_prio (
        .req   (isr_q),
        .valid (isr_valid),
        .idx   (isr_top)
    );

    // Only bits strictly above the highest in-service level may preempt.
    assign above         = isr_valid ? (8'hFF << ({1'b0, isr_top} + 4'd1)) : 8'hFF;
    assign isr_after_eoi = isr_valid ? (isr_q & ~onehot(isr_top)) : isr_q;
`else
    // Single level: nothing is eligible while any interrupt is in service.
    assign above         = (isr_q == '0) ? 8'hFF : 8'h00;
    assign isr_after_eoi = '0;
`endif

    assign eligible = pending_q & mask_q & above;

    uvect_prio u_elig_prio (
        .req   (eligible),
        .valid (elig_valid),
        .idx   (elig_idx)
    );

    // A CJV that is taken: vector selected, request live, condition passes.
    assign ack     = ~nVECT & int_req_q & (nCCEN | ~nCC);
    assign ack_bit = ack ? onehot(ack_idx_q) : '0;

    // A fresh edge on the bit being acknowledged wins over the clear.
    assign pending_next = (pending_q & ~ack_bit) | rise;
    assign isr_next     = (eoi ? isr_after_eoi : isr_q) | ack_bit;

    always_comb begin
        D = '0;
        if (!nPL)        D = pl_d;
        else if (!nMAP)  D = make_map(MAP_PAGE, opcode_q);
        else if (!nVECT) D = vec_q;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            opcode_q  <= '0;
            irq_q     <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            isr_q     <= '0;
            // NOTE: reset values are whatever is safe to present, not
            // necessarily zero: an early CJV must see the spurious vector.
            vec_q     <= SPUR_VEC;
            int_req_q <= 1'b0;
            ack_idx_q <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples the
            // pre-edge values regardless of statement order.
            irq_q     <= irq;
            pending_q <= pending_next;
            isr_q     <= isr_next;
            if (op_load) opcode_q <= opcode;
            if (mask_we) mask_q   <= mask_wd;
            // The vector is frozen while selected so D is stable across CJV.
            if (nVECT) begin
                vec_q     <= elig_valid ? make_vector(VEC_PAGE, elig_idx) : SPUR_VEC;
                int_req_q <= elig_valid;
                ack_idx_q <= elig_idx;
            end
        end
    end

    assign int_req = int_req_q;
    assign pending = pending_q;
    assign isr     = isr_q;

endmodule

// File: tb/tb_uvect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uvect_ctrl -- self-checking bench for uvect_ctrl (default parameters).
// A behavioural model tracks pending/isr/mask and the held vector; every
// tick compares all outputs against it, and directed literal checks pin the
// model at the interesting points. Honours UVECT_NEST_EN like the design.
// -----------------------------------------------------------------------------
module tb_uvect_ctrl;

    logic        clk;
    logic        nRESET;
    logic        nPL, nMAP, nVECT, nCCEN, nCC;
    logic [11:0] pl_d;
    logic        op_load;
    logic [7:0]  opcode;
    logic [7:0]  irq;
    logic        mask_we;
    logic [7:0]  mask_wd;
    logic        eoi;
    logic [11:0] D;
    logic        int_req;
    logic [7:0]  pending, isr;

    int checks   = 0;
    int failures = 0;

    uvect_ctrl dut (
        .clk     (clk),
        .nRESET  (nRESET),
        .nPL     (nPL),
        .nMAP    (nMAP),
        .nVECT   (nVECT),
        .nCCEN   (nCCEN),
        .nCC     (nCC),
        .pl_d    (pl_d),
        .op_load (op_load),
        .opcode  (opcode),
        .irq     (irq),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .eoi     (eoi),
        .D       (D),
        .int_req (int_req),
        .pending (pending),
        .isr     (isr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pending, m_isr, m_mask, m_prev, m_op;
    logic [11:0] m_vec;
    logic        m_int_req;
    int          m_ack_idx;

    logic [7:0]  nx_pending, nx_isr;
    int          best;
    bit          take;

    function automatic int top_bit(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit may_take(input int i, input logic [7:0] s);
`ifdef UVECT_NEST_EN
        return i > top_bit(s);
`else
        return s == 8'h00;
`endif
    endfunction

    function automatic logic [11:0] model_d();
        if (!nPL)   return pl_d;
        if (!nMAP)  return 12'h400 | (12'(m_op) << 2);
        if (!nVECT) return m_vec;
        return 12'h000;
    endfunction

    always @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            m_pending <= 8'h00;
            m_isr     <= 8'h00;
            m_mask    <= 8'h00;
            m_prev    <= 8'h00;
            m_op      <= 8'h00;
            m_vec     <= 12'hFB8;
            m_int_req <= 1'b0;
            m_ack_idx <= 0;
        end else begin
            best = -1;
            for (int i = 7; i >= 0; i--)
                if (best < 0 && m_pending[i] && m_mask[i] && may_take(i, m_isr)) best = i;
            take       = !nVECT && m_int_req && (nCCEN || !nCC);
            nx_pending = m_pending;
            nx_isr     = m_isr;
            if (eoi && top_bit(m_isr) >= 0) begin
`ifdef UVECT_NEST_EN
                nx_isr[top_bit(m_isr)] = 1'b0;
`else
                nx_isr = 8'h00;
`endif
            end
            if (take) begin
                nx_isr[m_ack_idx]     = 1'b1;
                nx_pending[m_ack_idx] = 1'b0;
            end
            for (int i = 0; i < 8; i++) if (irq[i] && !m_prev[i]) nx_pending[i] = 1'b1;
            m_pending <= nx_pending;
            m_isr     <= nx_isr;
            m_prev    <= irq;
            if (mask_we) m_mask <= mask_wd;
            if (op_load) m_op   <= opcode;
            if (nVECT) begin
                m_int_req <= (best >= 0);
                m_vec     <= (best >= 0) ? 12'hFC0 + 12'(best * 8) : 12'hFB8;
                m_ack_idx <= (best >= 0) ? best : 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        @(negedge clk);
        check("model_D",       D,                 model_d());
        check("model_int_req", {11'b0, int_req},  {11'b0, m_int_req});
        check("model_pending", {4'b0, pending},   {4'b0, m_pending});
        check("model_isr",     {4'b0, isr},       {4'b0, m_isr});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        nRESET = 1'b0; nPL = 1'b1; nMAP = 1'b1; nVECT = 1'b1;
        nCCEN = 1'b1; nCC = 1'b1; pl_d = 12'h000; op_load = 1'b0;
        opcode = 8'h00; irq = 8'h00; mask_we = 1'b0; mask_wd = 8'h00; eoi = 1'b0;

        // Reset state
        ticks(2);
        check("rst_pending", {4'b0, pending}, 12'h000);
        check("rst_isr",     {4'b0, isr},     12'h000);
        check("rst_int_req", {11'b0, int_req}, 12'h000);
        nVECT = 1'b0; #1;
        check("rst_vector", D, 12'hFB8);
        nVECT = 1'b1;
        nRESET = 1'b1;
        tick();

        // Source mux
        nPL = 1'b0; pl_d = 12'h123; #1;
        check("mux_pl", D, 12'h123);
        op_load = 1'b1; opcode = 8'h5A;
        tick();
        op_load = 1'b0; nPL = 1'b1; nMAP = 1'b0; #1;
        check("mux_map", D, 12'h568);
        tick();
        nMAP = 1'b1;

        // Single interrupt
        mask_we = 1'b1; mask_wd = 8'hFF;
        tick();
        mask_we = 1'b0; irq = 8'h08;
        ticks(1);
        check("single_not_yet", {11'b0, int_req}, 12'h000);
        ticks(1);
        check("single_int_req", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; #1;
        check("single_vector", D, 12'hFD8);
        tick();
        check("single_isr",     {4'b0, isr},     12'h008);
        check("single_pending", {4'b0, pending}, 12'h000);
        nVECT = 1'b1; irq = 8'h00;
        pulse_eoi();
        check("single_eoi", {4'b0, isr}, 12'h000);

        // Priority: bits 2 and 5
        irq = 8'h24;
        tick();
        irq = 8'h00;
        tick();
        check("prio_int_req", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; #1;
        check("prio_vector5", D, 12'hFE8);
        tick();
        check("prio_isr5",     {4'b0, isr},     12'h020);
        check("prio_pending2", {4'b0, pending}, 12'h004);
        nVECT = 1'b1;
        tick();
        check("prio_lower_waits", {11'b0, int_req}, 12'h000);
        pulse_eoi();
        tick();
        check("prio_int_req2", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; #1;
        check("prio_vector2", D, 12'hFD0);
        tick();
        check("prio_isr2", {4'b0, isr}, 12'h004);

        // Higher request while bit 2 is in service
        nVECT = 1'b1; irq = 8'h40;
        tick();
        irq = 8'h00;
        tick();
`ifdef UVECT_NEST_EN
        check("nest_preempt", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; eoi = 1'b1; #1;
        check("nest_vector6", D, 12'hFF0);
        tick();
        eoi = 1'b0; nVECT = 1'b1;
        check("nest_eoi_ack_isr", {4'b0, isr},     12'h040);
        check("nest_pending",     {4'b0, pending}, 12'h000);
        pulse_eoi();
`else
        check("single_level_wait", {11'b0, int_req}, 12'h000);
        pulse_eoi();
        tick();
        check("after_eoi_int_req", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; #1;
        check("after_eoi_vector6", D, 12'hFF0);
        tick();
        check("after_eoi_isr", {4'b0, isr}, 12'h040);
        nVECT = 1'b1;
        pulse_eoi();
`endif
        check("nest_isr_clear", {4'b0, isr}, 12'h000);

        // New edge on the bit being acknowledged
        irq = 8'h02;
        tick();
        irq = 8'h00;
        tick();
        nVECT = 1'b0; irq = 8'h02; #1;
        check("same_bit_vector", D, 12'hFC8);
        tick();
        check("same_bit_isr",     {4'b0, isr},     12'h002);
        check("same_bit_pending", {4'b0, pending}, 12'h002);
        nVECT = 1'b1; irq = 8'h00;
        pulse_eoi();
        tick();
        check("same_bit_rereq", {11'b0, int_req}, 12'h001);

        // Failed CJV, then passing conditional CJV
        nVECT = 1'b0; nCCEN = 1'b0; nCC = 1'b1;
        tick();
        check("fail_cjv_pending", {4'b0, pending}, 12'h002);
        check("fail_cjv_isr",     {4'b0, isr},     12'h000);
        nCC = 1'b0;
        tick();
        check("pass_cjv_isr", {4'b0, isr}, 12'h002);
        nVECT = 1'b1; nCCEN = 1'b1; nCC = 1'b1;
        pulse_eoi();

        // Spurious: everything masked
        mask_we = 1'b1; mask_wd = 8'h00;
        tick();
        mask_we = 1'b0; irq = 8'h80;
        tick();
        irq = 8'h00;
        tick();
        check("spur_int_req", {11'b0, int_req}, 12'h000);
        nVECT = 1'b0; #1;
        check("spur_vector", D, 12'hFB8);
        tick();
        check("spur_no_ack_pending", {4'b0, pending}, 12'h080);
        check("spur_no_ack_isr",     {4'b0, isr},     12'h000);
        nVECT = 1'b1;
        ticks(3);
        check("masked_stays_pending", {4'b0, pending}, 12'h080);

        // Mask write takes effect a cycle later
        mask_we = 1'b1; mask_wd = 8'h80;
        tick();
        mask_we = 1'b0;
        check("mask_delay", {11'b0, int_req}, 12'h000);
        tick();
        check("mask_live", {11'b0, int_req}, 12'h001);
        nVECT = 1'b0; #1;
        check("mask_vector7", D, 12'hFF8);
        tick();
        check("mask_isr7", {4'b0, isr}, 12'h080);
        nVECT = 1'b1;

        // Reset mid-service
        #2 nRESET = 1'b0; #1;
        check("midrst_isr",     {4'b0, isr},      12'h000);
        check("midrst_pending", {4'b0, pending},  12'h000);
        check("midrst_int_req", {11'b0, int_req}, 12'h000);
        nVECT = 1'b0; #1;
        check("midrst_vector", D, 12'hFB8);
        nVECT = 1'b1;
        tick();
        nRESET = 1'b1;
        irq = 8'h01;
        ticks(3);
        check("midrst_mask_cleared", {11'b0, int_req}, 12'h000);
        check("midrst_new_pending",  {4'b0, pending},  12'h001);
        irq = 8'h00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uvect_ctrl.md
UVECT_CTRL -- requirements
Module: uvect_ctrl

Interface
REQ-001 SHALL have parameter MAP_PAGE, default 2'b01, upper two bits of every mapping address.
REQ-002 SHALL have parameter VEC_PAGE, default 6'b111111, upper six bits of every interrupt vector.
REQ-003 SHALL have parameter SPUR_VEC, default 12'hFB8, vector driven when no interrupt is eligible.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 nRESET  input  1  reset, asynchronous, active-low.
REQ-006 nPL, nMAP, nVECT  input  1 each  Am2910 source enables, active-low, at most one low.
REQ-007 nCCEN, nCC  input  1 each  same condition signals the sequencer receives.
REQ-008 pl_d  input  12  branch field of the microinstruction pipeline register.
REQ-009 op_load, opcode  input  1, 8  opcode register load strobe and data.
REQ-010 irq  input  8  synchronous interrupt request lines; bit 7 is highest priority.
REQ-011 mask_we, mask_wd  input  1, 8  mask register write strobe and data; 1 = enabled.
REQ-012 eoi  input  1  end-of-interrupt pulse.
REQ-013 D  output  12  sequencer D input.
REQ-014 int_req  output  1  registered; an eligible interrupt exists.
REQ-015 pending, isr  output  8 each  pending and in-service registers.

Function
REQ-016 D SHALL equal pl_d when nPL=0, map address when nMAP=0, and vector register when nVECT=0, combinationally.
REQ-017 Map address SHALL be {MAP_PAGE, opcode_q, 2'b00}; opcode_q SHALL load on op_load and be visible on the next cycle.
REQ-018 A rising edge SHALL set the matching pending bit; an edge is irq=1 with the previous-cycle irq=0.
REQ-019 Eligible = pending & mask & (bits strictly above the highest set isr bit); with isr=0 all bits are above.
REQ-020 While nVECT=1, each edge SHALL load the vector register with {VEC_PAGE, idx, 3'b000}, where idx is the highest eligible bit. If none is eligible it SHALL load SPUR_VEC. int_req SHALL load "any eligible".
REQ-021 While nVECT=0, the vector register and int_req SHALL hold, so D is stable for the whole CJV cycle.
REQ-022 Acknowledge SHALL occur at an edge with nVECT=0, int_req=1 and (nCCEN=1 or nCC=0).
REQ-023 Acknowledge SHALL clear the acknowledged pending bit and set the same isr bit.
REQ-024 A failed CJV, or nVECT=0 with int_req=0, SHALL change no pending or isr bit.
REQ-025 eoi SHALL clear the highest set isr bit; eoi with isr=0 SHALL have no effect.
REQ-026 Simultaneous events:
- A new edge on the bit being acknowledged SHALL leave that pending bit set.
- When eoi and acknowledge coincide, isr_next SHALL equal (isr minus highest bit) plus the acknowledged bit.
- A mask write SHALL take effect for eligibility on the next cycle.
REQ-027 Masked pending bits SHALL remain pending indefinitely.

Reset
REQ-028 nRESET=0 SHALL asynchronously clear:
- pending, isr and mask (all interrupts disabled);
- opcode_q and the previous-irq register;
- int_req.
It SHALL also load the vector register with SPUR_VEC. Reset mid-service SHALL discard all in-service state.

Configuration
REQ-029 With UVECT_NEST_EN defined, nested priority SHALL follow REQ-019.
REQ-030 Without UVECT_NEST_EN, eligibility SHALL be pending & mask & (isr==0): a single level, where eoi clears isr entirely.

Structure
REQ-031 A shared package uvect_pkg SHALL hold the priority-index type, the vector/map layout constants and SPUR_VEC's default.
REQ-032 The priority encoder SHALL be sub-module uvect_prio (8-bit in; valid and 3-bit index out).

Verification
REQ-033 Mux: nPL=0 with pl_d=12'h123 -> D=12'h123; op_load with 8'h5A, then nMAP=0 -> D=12'h568.
REQ-034 Single interrupt: mask=8'hFF, irq[3] rises -> int_req=1 two edges later; nVECT=0 -> D=12'hFD8; after the edge -> isr=8'h08, pending=0.
REQ-035 Priority and nesting: pending bits 2 and 5 -> vector 12'hFE8. Ack then eoi sequence: isr 8'h20 -> eoi -> bit 2 served (12'hFD0). Without UVECT_NEST_EN, bit 2 SHALL wait until eoi.
REQ-036 Failed CJV: int_req=1, nVECT=0, nCCEN=0, nCC=1 -> pending and isr unchanged.
REQ-037 Spurious: masks all 0, nVECT=0 -> D=12'hFB8, no ack. Also: nRESET pulse while isr=8'h80 -> isr=0 and D=SPUR_VEC on vector select.
